l0_scaler_ctrl: RTL

Periodic gate/readout controller for a bank of L0 scaler channels. Takes the per-channel single-cycle scaler pulses and stuck flags, all already synchronised to mclk. Counts the pulses over a programmable gate period, snapshots the counts at the end of each period, and serves the snapshot to a slow register reader through a request/valid/done handshake. Sits between the per-channel L0 scaler front ends and the register interface.

---
 rtl/l0_scaler_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/l0_scaler_ctrl.sv
// l0_scaler_ctrl: gate/readout controller for a bank of L0 scaler channels.
// Counts per-channel pulses over a programmable gate, snapshots the counts
// at the end of each gate and serves the snapshot through a req/valid/done
// handshake. A snapshot is only replaced once the reader has released it.
module l0_scaler_ctrl #(
    parameter int NUM_CH    = 12,
    parameter int CNT_WIDTH = 16,
    parameter int PERIOD_W  = 24
) (
    input  logic                 mclk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic [PERIOD_W-1:0]  period_i,
    input  logic [NUM_CH-1:0]    mask_i,
    input  logic [NUM_CH-1:0]    pulse_i,
    input  logic [NUM_CH-1:0]    stuck_i,
    input  logic                 rd_req_i,
    input  logic [3:0]           rd_addr_i,
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 rd_done_i,
    output logic                 data_ready_o,
    output logic [NUM_CH-1:0]    stuck_o,
    output logic                 missed_o,
    output logic [PERIOD_W-1:0]  gate_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SNAP  = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [PERIOD_W-1:0]                timer_q, timer_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  stk_q, stk_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]   snap_q, snap_d;
    logic [NUM_CH-1:0]                  stuck_q, stuck_d;
    logic                               ready_q, ready_d;
    logic                               missed_q, missed_d;
    logic                               rvalid_q, rvalid_d;
    logic [CNT_WIDTH-1:0]               rdata_q, rdata_d;

    logic [PERIOD_W-1:0]                reload;
    logic                               live_run;
    logic                               in_snap;
    logic                               accept;
    logic [CNT_WIDTH-1:0]               rd_sel;

    // Reload value P-1 with P clamped to at least 2 cycles
    always_comb begin
        reload = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1) : period_i - PERIOD_W'(1);
    end

    // Gate sequencing: IDLE -> COUNT (P cycles) -> SNAP -> COUNT ...
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!enable_i) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_COUNT;
                    timer_d = reload;
                end
                S_COUNT: begin
                    if (timer_q == '0) state_d = S_SNAP;
                    else               timer_d = timer_q - PERIOD_W'(1);
                end
                S_SNAP: begin
                    state_d = S_COUNT;
                    timer_d = reload;
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Live saturating counters and sticky stuck flags; SNAP restarts a period
    always_comb begin
        live_run = enable_i && (state_q == S_COUNT || state_q == S_SNAP);
        in_snap  = enable_i && (state_q == S_SNAP);
        cnt_d    = cnt_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!live_run || mask_i[ch])
                cnt_d[ch] = '0;
            else if (in_snap)
                cnt_d[ch] = CNT_WIDTH'(pulse_i[ch]);
            else if (pulse_i[ch] && cnt_q[ch] != {CNT_WIDTH{1'b1}})
                cnt_d[ch] = cnt_q[ch] + CNT_WIDTH'(1);
        end
        if (!live_run)    stk_d = '0;
        else if (in_snap) stk_d = stuck_i;
        else              stk_d = stk_q | stuck_i;
    end

    // Snapshot handoff: a release in the SNAP cycle lets the new snapshot in
    always_comb begin
        accept   = in_snap && (!ready_q || rd_done_i);
        snap_d   = accept ? cnt_q : snap_q;
        stuck_d  = accept ? stk_q : stuck_q;
        ready_d  = ready_q;
        missed_d = missed_q;
        if (accept)
            ready_d = 1'b1;
        else if (rd_done_i && ready_q)
            ready_d = 1'b0;
        if (rd_done_i && ready_q)
            missed_d = 1'b0;
        else if (in_snap && ready_q)
            missed_d = 1'b1;
    end

    // Read port: one-cycle latency from the pre-update snapshot, data held
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_addr_i == 4'(c)) rd_sel = snap_q[c];
        end
        rvalid_d = rd_req_i;
        rdata_d  = rd_req_i ? rd_sel : rdata_q;
    end

    // State registers
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            stk_q    <= '0;
            snap_q   <= '0;
            stuck_q  <= '0;
            ready_q  <= 1'b0;
            missed_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            stk_q    <= stk_d;
            snap_q   <= snap_d;
            stuck_q  <= stuck_d;
            ready_q  <= ready_d;
            missed_q <= missed_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rd_data_o    = rdata_q;
    assign rd_valid_o   = rvalid_q;
    assign data_ready_o = ready_q;
    assign stuck_o      = stuck_q;
    assign missed_o     = missed_q;
    assign gate_cnt_o   = timer_q;

endmodule
